// File: rtl/frame_buf_rd_arbiter_pkg.sv
// fb_pkg: frame-buffer geometry, requester IDs and read-arbiter FSM encoding.
package fb_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int ADDR_W = 19;
  localparam int FRAME_PIX = 307200;
  localparam logic REQ_DISP = 1'b0;
  localparam logic REQ_FILT = 1'b1;
  typedef enum logic {WAIT_FRAME, SERVE} state_t;
endpackage

// File: rtl/frame_buf_rd_arbiter_if.sv
// frame_buf_rd_arbiter_if: requester/BRAM-side bundle of the frame-buffer read arbiter.
interface frame_buf_rd_arbiter_if;
  import fb_pkg::*;
  logic i_flush;
  logic i_frame_done;
  logic o_frame_ready;
  logic i_req0;
  logic [ADDR_W-1:0] i_addr0;
  logic o_gnt0;
  logic o_vld0;
  logic i_req1;
  logic [ADDR_W-1:0] i_addr1;
  logic o_gnt1;
  logic o_vld1;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic [ADDR_W-1:0] o_raddr;
  logic [DATA_WIDTH-1:0] i_bram_rdata;
  logic o_addr_err;
  modport master (
    output i_flush, i_frame_done, i_req0, i_addr0, i_req1, i_addr1, i_bram_rdata,
    input o_frame_ready, o_gnt0, o_vld0, o_gnt1, o_vld1, o_rdata, o_raddr, o_addr_err
  );
  modport slave (
    input i_flush, i_frame_done, i_req0, i_addr0, i_req1, i_addr1, i_bram_rdata,
    output o_frame_ready, o_gnt0, o_vld0, o_gnt1, o_vld1, o_rdata, o_raddr, o_addr_err
  );
endinterface

// File: rtl/frame_buf_rd_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep delay line of {vld,id} matching the BRAM read latency.
module rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_vld,
  input  logic i_id,
  output logic o_vld,
  output logic o_id
);
  logic [1:0] r_sr [RD_LAT];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < RD_LAT; i++) r_sr[i] <= '0;
    else if (i_clr) for (int i = 0; i < RD_LAT; i++) r_sr[i] <= '0;
    else begin
      r_sr[0] <= {i_vld, i_id};
      for (int i = 1; i < RD_LAT; i++) r_sr[i] <= r_sr[i-1];
    end
  assign {o_vld, o_id} = r_sr[RD_LAT-1];
endmodule

// File: rtl/frame_buf_rd_arbiter.sv
// frame_buf_rd_arbiter: shares the frame-buffer BRAM read port between scan-out and filter fetch.
module frame_buf_rd_arbiter
  import fb_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int STARVE_MAX = 8
) (
  input logic clk,
  input logic rst,
  frame_buf_rd_arbiter_if.slave bus
);
  state_t r_state;
  logic [3:0] r_starve;
  logic [ADDR_W-1:0] r_raddr;
  logic r_addr_err;
  logic w_serve, w_gnt0, w_gnt1, w_gnt, w_bad, w_pvld, w_pid;
  logic [ADDR_W-1:0] w_gaddr, w_raddr;
  always_comb begin
    w_serve = r_state == SERVE && !bus.i_flush;
    w_gnt1 = w_serve && bus.i_req1 && (!bus.i_req0 || r_starve == 4'(STARVE_MAX));
    w_gnt0 = w_serve && bus.i_req0 && !w_gnt1;
    w_gnt = w_gnt0 || w_gnt1;
    w_gaddr = w_gnt1 ? bus.i_addr1 : bus.i_addr0;
    w_bad = w_gnt && w_gaddr >= ADDR_W'(FRAME_PIX);
    w_raddr = w_gnt ? (w_bad ? '0 : w_gaddr) : r_raddr;
  end
  // Starvation is only counted while serving so a fresh frame starts with REQ0 priority.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= WAIT_FRAME;
      r_starve <= '0;
      r_raddr <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_raddr <= w_raddr;
      r_addr_err <= r_addr_err | w_bad;
      if (bus.i_flush) begin
        r_state <= WAIT_FRAME;
        r_starve <= '0;
      end else begin
        if (r_state == WAIT_FRAME && bus.i_frame_done) r_state <= SERVE;
        r_starve <= (r_state != SERVE || !bus.i_req1 || w_gnt1) ? '0 :
                    (r_starve == 4'(STARVE_MAX)) ? r_starve : r_starve + 4'd1;
      end
    end
  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk(clk),
    .rst(rst),
    .i_clr(bus.i_flush),
    .i_vld(w_gnt),
    .i_id(w_gnt1 ? REQ_FILT : REQ_DISP),
    .o_vld(w_pvld),
    .o_id(w_pid)
  );
  assign bus.o_gnt0 = w_gnt0;
  assign bus.o_gnt1 = w_gnt1;
  assign bus.o_raddr = w_raddr;
  assign bus.o_frame_ready = r_state == SERVE;
  assign bus.o_addr_err = r_addr_err;
  assign bus.o_vld0 = w_pvld && w_pid == REQ_DISP;
  assign bus.o_vld1 = w_pvld && w_pid == REQ_FILT;
  assign bus.o_rdata = w_pvld ? bus.i_bram_rdata : '0;
endmodule

// File: tb/tb_frame_buf_rd_arbiter.sv
// tb_frame_buf_rd_arbiter: directed checks of gating, arbitration, range error, flush and reset.
module tb_frame_buf_rd_arbiter;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_err = 0;
  logic [18:0] r_m1, r_m2;
  logic e1, ev1;
  frame_buf_rd_arbiter_if bus ();
  frame_buf_rd_arbiter #(.RD_LAT(2), .STARVE_MAX(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] mem_f(input logic [18:0] a);
    return a[11:0] ^ 12'h5A3;
  endfunction
  // Two-cycle BRAM model
  always_ff @(posedge clk) begin
    r_m1 <= bus.o_raddr;
    r_m2 <= r_m1;
  end
  assign bus.i_bram_rdata = mem_f(r_m2);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.i_flush = 1'b0;
    bus.i_frame_done = 1'b0;
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    bus.i_addr0 = '0;
    bus.i_addr1 = '0;
    repeat (3) cyc();
    #1;
    chk("rst_gnt0", 32'(bus.o_gnt0), 0);
    chk("rst_gnt1", 32'(bus.o_gnt1), 0);
    chk("rst_vld0", 32'(bus.o_vld0), 0);
    chk("rst_vld1", 32'(bus.o_vld1), 0);
    chk("rst_rdata", 32'(bus.o_rdata), 0);
    chk("rst_raddr", 32'(bus.o_raddr), 0);
    chk("rst_ready", 32'(bus.o_frame_ready), 0);
    chk("rst_err", 32'(bus.o_addr_err), 0);
    rst = 1'b0;
    // 1: no frame yet
    for (int i = 0; i < 20; i++) begin
      cyc();
      bus.i_req0 = 1'b1;
      bus.i_addr0 = 19'd5;
      #1;
      chk("t1_gnt0", 32'(bus.o_gnt0), 0);
      chk("t1_vld0", 32'(bus.o_vld0), 0);
      chk("t1_ready", 32'(bus.o_frame_ready), 0);
    end
    // 2: first read after frame_done
    cyc();
    bus.i_req0 = 1'b0;
    bus.i_frame_done = 1'b1;
    #1;
    chk("t2_ready_pre", 32'(bus.o_frame_ready), 0);
    cyc();
    bus.i_frame_done = 1'b0;
    bus.i_req0 = 1'b1;
    #1;
    chk("t2_ready", 32'(bus.o_frame_ready), 1);
    chk("t2_gnt0", 32'(bus.o_gnt0), 1);
    chk("t2_raddr", 32'(bus.o_raddr), 5);
    cyc();
    bus.i_req0 = 1'b0;
    #1;
    chk("t2_vld0_early", 32'(bus.o_vld0), 0);
    cyc();
    #1;
    chk("t2_vld0", 32'(bus.o_vld0), 1);
    chk("t2_vld1", 32'(bus.o_vld1), 0);
    chk("t2_rdata", 32'(bus.o_rdata), 32'(mem_f(19'd5)));
    cyc();
    #1;
    chk("t2_vld0_late", 32'(bus.o_vld0), 0);
    chk("t2_raddr_hold", 32'(bus.o_raddr), 5);
    // 3: starvation pattern, 8 x REQ0 then 1 x REQ1
    for (int i = 1; i <= 18; i++) begin
      cyc();
      bus.i_req0 = 1'b1;
      bus.i_addr0 = 19'd10;
      bus.i_req1 = 1'b1;
      bus.i_addr1 = 19'd20;
      #1;
      e1 = (i % 9 == 0);
      ev1 = (i > 2) && ((i - 2) % 9 == 0);
      chk("t3_gnt1", 32'(bus.o_gnt1), 32'(e1));
      chk("t3_gnt0", 32'(bus.o_gnt0), 32'(!e1));
      chk("t3_raddr", 32'(bus.o_raddr), e1 ? 32'd20 : 32'd10);
      chk("t3_vld1", 32'(bus.o_vld1), 32'(ev1));
      chk("t3_vld0", 32'(bus.o_vld0), 32'(i > 2 && !ev1));
      if (ev1) chk("t3_rdata1", 32'(bus.o_rdata), 32'(mem_f(19'd20)));
    end
    cyc();
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    repeat (2) cyc();
    // 4: range boundary on REQ1
    cyc();
    bus.i_req1 = 1'b1;
    bus.i_addr1 = 19'd307199;
    #1;
    chk("t4_gnt1_last", 32'(bus.o_gnt1), 1);
    chk("t4_raddr_last", 32'(bus.o_raddr), 307199);
    chk("t4_err_clean", 32'(bus.o_addr_err), 0);
    cyc();
    bus.i_addr1 = 19'd307200;
    #1;
    chk("t4_gnt1_oob", 32'(bus.o_gnt1), 1);
    chk("t4_raddr_oob", 32'(bus.o_raddr), 0);
    cyc();
    bus.i_req1 = 1'b0;
    #1;
    chk("t4_err_set", 32'(bus.o_addr_err), 1);
    chk("t4_vld1_last", 32'(bus.o_vld1), 1);
    chk("t4_rdata_last", 32'(bus.o_rdata), 32'(mem_f(19'd307199)));
    cyc();
    #1;
    chk("t4_vld1_oob", 32'(bus.o_vld1), 1);
    chk("t4_rdata_oob", 32'(bus.o_rdata), 32'(mem_f(19'd0)));
    chk("t4_raddr_hold", 32'(bus.o_raddr), 0);
    repeat (3) cyc();
    chk("t4_err_sticky", 32'(bus.o_addr_err), 1);
    // 5: flush one cycle after a grant
    cyc();
    bus.i_req0 = 1'b1;
    bus.i_addr0 = 19'd7;
    #1;
    chk("t5_gnt0", 32'(bus.o_gnt0), 1);
    cyc();
    bus.i_req0 = 1'b0;
    bus.i_flush = 1'b1;
    #1;
    chk("t5_ready_flushcyc", 32'(bus.o_frame_ready), 1);
    cyc();
    bus.i_flush = 1'b0;
    #1;
    chk("t5_vld0", 32'(bus.o_vld0), 0);
    chk("t5_ready", 32'(bus.o_frame_ready), 0);
    cyc();
    bus.i_req0 = 1'b1;
    #1;
    chk("t5_vld0_late", 32'(bus.o_vld0), 0);
    chk("t5_gnt0_wait", 32'(bus.o_gnt0), 0);
    // flush beats frame_done in the same cycle
    cyc();
    bus.i_req0 = 1'b0;
    bus.i_flush = 1'b1;
    bus.i_frame_done = 1'b1;
    cyc();
    bus.i_flush = 1'b0;
    bus.i_frame_done = 1'b0;
    #1;
    chk("t5_flush_wins", 32'(bus.o_frame_ready), 0);
    // 6: asynchronous reset mid-burst
    cyc();
    bus.i_frame_done = 1'b1;
    cyc();
    bus.i_frame_done = 1'b0;
    bus.i_req0 = 1'b1;
    bus.i_addr0 = 19'd9;
    #1;
    chk("t6_gnt0", 32'(bus.o_gnt0), 1);
    repeat (2) cyc();
    #1;
    chk("t6_vld0_pre", 32'(bus.o_vld0), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_gnt0_rst", 32'(bus.o_gnt0), 0);
    chk("t6_vld0_rst", 32'(bus.o_vld0), 0);
    chk("t6_ready_rst", 32'(bus.o_frame_ready), 0);
    chk("t6_raddr_rst", 32'(bus.o_raddr), 0);
    chk("t6_rdata_rst", 32'(bus.o_rdata), 0);
    chk("t6_err_rst", 32'(bus.o_addr_err), 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_gnt0_wait", 32'(bus.o_gnt0), 0);
    cyc();
    #1;
    chk("t6_gnt0_wait2", 32'(bus.o_gnt0), 0);
    chk("t6_ready_wait", 32'(bus.o_frame_ready), 0);
    cyc();
    bus.i_frame_done = 1'b1;
    cyc();
    bus.i_frame_done = 1'b0;
    #1;
    chk("t6_gnt0_again", 32'(bus.o_gnt0), 1);
    chk("t6_raddr_again", 32'(bus.o_raddr), 9);
    cyc();
    bus.i_req0 = 1'b0;
    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
